// File: rtl/idft_synth_ff.sv
// Serial inverse DFT: loads BIN_NUM complex bins, then synthesises one time sample per read request.
// Optional IDFT_HERMITIAN_EN doubles every bin k>=1 for real-signal (conjugate-symmetric) synthesis.
module idft_synth_ff #(
  parameter int WIDTH     = 12,
  parameter int N_MAX     = 512,
  parameter int FRAC_BITS = 4,
  parameter int BIN_NUM   = 4
) (
  input  logic                    i_sys_clk,
  input  logic                    i_sys_rst,
  input  logic signed [WIDTH-1:0] i_re,
  input  logic signed [WIDTH-1:0] i_im,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic                    i_rd,
  output logic signed [WIDTH-1:0] o_x,
  output logic                    o_valid,
  output logic                    o_done
);

  localparam int unsigned IW = $clog2(N_MAX);
  localparam int unsigned BW = (BIN_NUM > 1) ? $clog2(BIN_NUM) : 1;
  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned TW = 2 * WIDTH + 1;
  localparam int unsigned AW = 2 * WIDTH + $clog2(BIN_NUM) + 2;
  localparam real         PI = 3.14159265358979323846;

  localparam logic signed [AW-1:0] SAT_HI = AW'((2 ** (WIDTH - 1)) - 1);
  localparam logic signed [AW-1:0] SAT_LO = -SAT_HI - AW'(1);

  typedef enum logic [2:0] {S_LOAD, S_IDLE, S_MUL_RE, S_MUL_IM, S_ACC, S_EMIT} state_t;

  logic signed [WIDTH-1:0] cos_lut [N_MAX];
  logic signed [WIDTH-1:0] sin_lut [N_MAX];

  // Twiddle tables are constants folded at elaboration.
  for (genvar gi = 0; gi < N_MAX; gi++) begin : g_lut
    assign cos_lut[gi] = WIDTH'($rtoi($cos(2.0 * PI * real'(gi) / real'(N_MAX)) * real'(2 ** FRAC_BITS)));
    assign sin_lut[gi] = WIDTH'($rtoi($sin(2.0 * PI * real'(gi) / real'(N_MAX)) * real'(2 ** FRAC_BITS)));
  end

  state_t                  state_q, state_d;
  logic [BW-1:0]           bin_cnt_q, bin_cnt_d;
  logic [IW-1:0]           n_q, n_d;
  logic [IW-1:0]           idx_q, idx_d;
  logic signed [AW-1:0]    acc_q, acc_d;
  logic signed [PW-1:0]    p_re_q, p_re_d;
  logic signed [PW-1:0]    p_im_q, p_im_d;
  logic signed [WIDTH-1:0] re_q [BIN_NUM];
  logic signed [WIDTH-1:0] re_d [BIN_NUM];
  logic signed [WIDTH-1:0] im_q [BIN_NUM];
  logic signed [WIDTH-1:0] im_d [BIN_NUM];
  logic signed [WIDTH-1:0] x_q, x_d;
  logic                    valid_q, valid_d;
  logic                    done_q, done_d;
  logic                    ready_q, ready_d;

  logic signed [WIDTH-1:0] mul_a, mul_b;
  logic signed [PW-1:0]    prod;
  logic signed [TW-1:0]    diff, term;
  logic signed [WIDTH-1:0] x_sat;

  // Single shared multiplier: real part against cos, imaginary part against sin.
  always_comb begin
    mul_a = re_q[bin_cnt_q];
    mul_b = cos_lut[idx_q];
    if (state_q == S_MUL_IM) begin
      mul_a = im_q[bin_cnt_q];
      mul_b = sin_lut[idx_q];
    end
    prod = PW'(mul_a) * PW'(mul_b);
  end

  always_comb begin
    diff = TW'(p_re_q) - TW'(p_im_q);
    term = diff >>> FRAC_BITS;
`ifdef IDFT_HERMITIAN_EN
    if (bin_cnt_q != '0) term = term <<< 1;
`endif
    if (acc_q > SAT_HI)      x_sat = WIDTH'(SAT_HI);
    else if (acc_q < SAT_LO) x_sat = WIDTH'(SAT_LO);
    else                     x_sat = WIDTH'(acc_q);
  end

  always_comb begin
    state_d   = state_q;
    bin_cnt_d = bin_cnt_q;
    n_d       = n_q;
    idx_d     = idx_q;
    acc_d     = acc_q;
    p_re_d    = p_re_q;
    p_im_d    = p_im_q;
    re_d      = re_q;
    im_d      = im_q;
    x_d       = x_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    ready_d   = ready_q;
    case (state_q)
      S_LOAD: begin
        if (i_valid && ready_q) begin
          re_d[bin_cnt_q] = i_re;
          im_d[bin_cnt_q] = i_im;
          if (bin_cnt_q == BW'(BIN_NUM - 1)) begin
            bin_cnt_d = '0;
            n_d       = '0;
            ready_d   = 1'b0;
            state_d   = S_IDLE;
          end else begin
            bin_cnt_d = bin_cnt_q + BW'(1);
          end
        end
      end
      S_IDLE: begin
        if (i_rd) begin
          acc_d     = '0;
          idx_d     = '0;
          bin_cnt_d = '0;
          state_d   = S_MUL_RE;
        end
      end
      S_MUL_RE: begin
        p_re_d  = prod;
        state_d = S_MUL_IM;
      end
      S_MUL_IM: begin
        p_im_d  = prod;
        state_d = S_ACC;
      end
      S_ACC: begin
        acc_d = acc_q + AW'(term);
        idx_d = idx_q + n_q;
        if (bin_cnt_q == BW'(BIN_NUM - 1)) begin
          state_d = S_EMIT;
        end else begin
          bin_cnt_d = bin_cnt_q + BW'(1);
          state_d   = S_MUL_RE;
        end
      end
      S_EMIT: begin
        x_d     = x_sat;
        valid_d = 1'b1;
        if (n_q == IW'(N_MAX - 1)) begin
          done_d    = 1'b1;
          n_d       = '0;
          bin_cnt_d = '0;
          ready_d   = 1'b1;
          state_d   = S_LOAD;
        end else begin
          n_d     = n_q + IW'(1);
          state_d = S_IDLE;
        end
      end
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge i_sys_clk) begin
    if (i_sys_rst) begin
      state_q   <= S_LOAD;
      bin_cnt_q <= '0;
      n_q       <= '0;
      idx_q     <= '0;
      acc_q     <= '0;
      p_re_q    <= '0;
      p_im_q    <= '0;
      re_q      <= '{default: '0};
      im_q      <= '{default: '0};
      x_q       <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
      ready_q   <= 1'b1;
    end else begin
      state_q   <= state_d;
      bin_cnt_q <= bin_cnt_d;
      n_q       <= n_d;
      idx_q     <= idx_d;
      acc_q     <= acc_d;
      p_re_q    <= p_re_d;
      p_im_q    <= p_im_d;
      re_q      <= re_d;
      im_q      <= im_d;
      x_q       <= x_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
      ready_q   <= ready_d;
    end
  end

  assign o_x     = x_q;
  assign o_valid = valid_q;
  assign o_done  = done_q;
  assign o_ready = ready_q;

endmodule

// File: tb/tb_idft_synth_ff.sv
// Self-checking bench for idft_synth_ff: directed frame table, corner sequences and random frames vs a DFT model.
module tb_idft_synth_ff;

  localparam int  W   = 12;
  localparam int  N   = 512;
  localparam int  F   = 4;
  localparam int  B   = 4;
  localparam int  LAT = 3 * B + 1;
  localparam real PI  = 3.14159265358979323846;
`ifdef IDFT_HERMITIAN_EN
  localparam bit HERM = 1'b1;
`else
  localparam bit HERM = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic i_valid = 1'b0;
  logic i_rd = 1'b0;
  logic signed [W-1:0] i_re = '0;
  logic signed [W-1:0] i_im = '0;
  logic signed [W-1:0] o_x;
  logic o_ready, o_valid, o_done;

  int n_chk  = 0;
  int n_pass = 0;
  bit stuck  = 1'b0;

  always #5 clk = ~clk;

  idft_synth_ff #(.WIDTH(W), .N_MAX(N), .FRAC_BITS(F), .BIN_NUM(B)) u_dut (
    .i_sys_clk(clk),
    .i_sys_rst(rst),
    .i_re     (i_re),
    .i_im     (i_im),
    .i_valid  (i_valid),
    .o_ready  (o_ready),
    .i_rd     (i_rd),
    .o_x      (o_x),
    .o_valid  (o_valid),
    .o_done   (o_done)
  );

  typedef struct packed {
    logic [B-1:0][15:0] re;
    logic [B-1:0][15:0] im;
    logic [3:0][9:0]    cn;
    logic [3:0][15:0]   ex;
  } vec_t;

  vec_t vecs [4];

  task automatic chk(input string name, input longint act, input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  function automatic longint lut_cos(input int i);
    return longint'($rtoi($cos(2.0 * PI * i / N) * (2.0 ** F)));
  endfunction

  function automatic longint lut_sin(input int i);
    return longint'($rtoi($sin(2.0 * PI * i / N) * (2.0 ** F)));
  endfunction

  // x[n] = sum_k (Re_k cos - Im_k sin) scaled back by the LUT fraction, then clipped to the output range.
  function automatic longint model_x(input int re[B], input int im[B], input int n);
    longint acc = 0;
    longint t;
    longint hi = (longint'(1) << (W - 1)) - 1;
    for (int k = 0; k < B; k++) begin
      int idx = (k * n) % N;
      t = (longint'(re[k]) * lut_cos(idx) - longint'(im[k]) * lut_sin(idx)) >>> F;
      if (HERM && k > 0) t = 2 * t;
      acc += t;
    end
    if (acc > hi) acc = hi;
    if (acc < -hi - 1) acc = -hi - 1;
    return acc;
  endfunction

  task automatic load(input int re[B], input int im[B]);
    for (int k = 0; k < B; k++) begin
      i_valid = 1'b1;
      i_re = W'(re[k]);
      i_im = W'(im[k]);
      chk("ready_in_load", o_ready, 1);
      @(posedge clk); @(negedge clk);
    end
    i_valid = 1'b0;
    chk("ready_after_load", o_ready, 0);
  endtask

  // One read request; lat counts edges from the sampling edge to the o_valid edge.
  task automatic read_sample(output longint x, output bit done, output int lat);
    x = 0; done = 1'b0; lat = 0;
    if (stuck) return;
    i_rd = 1'b1;
    @(posedge clk); @(negedge clk);
    i_rd = 1'b0;
    for (int c = 1; c <= 60; c++) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) begin
        lat = c;
        break;
      end
    end
    if (lat == 0) stuck = 1'b1;
    x = longint'(o_x);
    done = o_done;
  endtask

  task automatic run_table(input vec_t v, input int id);
    int re[B], im[B];
    longint x; bit done; int lat;
    for (int k = 0; k < B; k++) begin
      re[k] = int'($signed(v.re[k]));
      im[k] = int'($signed(v.im[k]));
    end
    load(re, im);
    for (int n = 0; n < N; n++) begin
      read_sample(x, done, lat);
      chk("latency", lat, LAT);
      if (stuck) break;
      chk("done", done, (n == N - 1));
      for (int j = 0; j < 4; j++)
        if (int'(v.cn[j]) == n)
          chk($sformatf("vec%0d_x_n%0d", id, n), x, longint'($signed(v.ex[j])));
    end
    chk("ready_after_done", o_ready, 1);
  endtask

  task automatic rand_frame(input bit special);
    int re[B], im[B];
    longint x; bit done; int lat; int cnt;
    for (int k = 0; k < B; k++) begin
      re[k] = int'($urandom_range(0, 4095)) - 2048;
      im[k] = int'($urandom_range(0, 4095)) - 2048;
    end
    load(re, im);
    if (special) begin
      i_valid = 1'b1;
      i_re = W'(int'($urandom_range(0, 4095)));
      i_im = W'(int'($urandom_range(0, 4095)));
      @(posedge clk); @(negedge clk);
      i_valid = 1'b0;
      chk("ready_idle", o_ready, 0);
    end
    for (int n = 0; n < N; n++) begin
      if (special && n == 5) begin
        i_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        i_rd = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); end
        i_rd = 1'b1;
        @(posedge clk); @(negedge clk);
        i_rd = 1'b0;
        cnt = 0;
        for (int c = 0; c < 40; c++) begin
          @(posedge clk); @(negedge clk);
          if (o_valid) begin
            cnt++;
            x = longint'(o_x);
            done = o_done;
          end
        end
        chk("single_valid_busy_rd", cnt, 1);
      end else begin
        read_sample(x, done, lat);
        chk("rand_latency", lat, LAT);
        if (stuck) break;
      end
      chk($sformatf("rand_x_n%0d", n), x, model_x(re, im, n));
      chk("rand_done", done, (n == N - 1));
    end
  endtask

  initial begin
    int cnt;
    longint x; bit done; int lat;
    int z[B];

    for (int i = 0; i < 4; i++) vecs[i] = '0;
    vecs[0].re[0] = 16'd32;
    vecs[0].cn[0] = 10'd0;   vecs[0].cn[1] = 10'd1;   vecs[0].cn[2] = 10'd255; vecs[0].cn[3] = 10'd511;
    for (int j = 0; j < 4; j++) vecs[0].ex[j] = 16'd32;
    vecs[1].re[1] = 16'd16;
    vecs[1].cn[0] = 10'd0;   vecs[1].cn[1] = 10'd128; vecs[1].cn[2] = 10'd256; vecs[1].cn[3] = 10'd384;
    vecs[1].ex[0] = HERM ? 16'd32 : 16'd16;
    vecs[1].ex[1] = 16'd0;
    vecs[1].ex[2] = HERM ? -16'sd32 : -16'sd16;
    vecs[1].ex[3] = 16'd0;
    for (int k = 0; k < B; k++) begin
      vecs[2].re[k] = 16'd2047;
      vecs[3].re[k] = -16'sd2048;
    end
    vecs[2].cn[0] = 10'd0;   vecs[2].cn[1] = 10'd256; vecs[2].cn[2] = 10'd1023; vecs[2].cn[3] = 10'd1023;
    vecs[2].ex[0] = 16'd2047;
    vecs[2].ex[1] = HERM ? -16'sd2047 : 16'd0;
    vecs[3].cn[0] = 10'd0;   vecs[3].cn[1] = 10'd256; vecs[3].cn[2] = 10'd1023; vecs[3].cn[3] = 10'd1023;
    vecs[3].ex[0] = -16'sd2048;
    vecs[3].ex[1] = HERM ? 16'd2047 : 16'd0;
    for (int k = 0; k < B; k++) z[k] = 0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_o_x", o_x, 0);
    chk("rst_o_valid", o_valid, 0);
    chk("rst_o_done", o_done, 0);
    chk("rst_o_ready", o_ready, 1);
    rst = 1'b0;

    // Reads are ignored while loading.
    i_rd = 1'b1;
    cnt = 0;
    repeat (20) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) cnt++;
    end
    i_rd = 1'b0;
    chk("rd_in_load_valids", cnt, 0);
    chk("rd_in_load_ready", o_ready, 1);

    for (int i = 0; i < 4; i++) run_table(vecs[i], i);

    // Reset while the third sample of a frame is in the imaginary multiply.
    z[0] = 300;
    load(z, z);
    read_sample(x, done, lat);
    read_sample(x, done, lat);
    i_rd = 1'b1;
    @(posedge clk); @(negedge clk);
    i_rd = 1'b0;
    @(posedge clk); @(negedge clk);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    rst = 1'b0;
    cnt = 0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (o_valid) cnt++;
    end
    chk("midrst_valids", cnt, 0);
    chk("midrst_o_x", o_x, 0);
    chk("midrst_o_ready", o_ready, 1);
    chk("midrst_o_done", o_done, 0);
    run_table(vecs[0], 4);

    rand_frame(1'b1);
    rand_frame(1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
